// File: rtl/motoro3_ramp_ctrl_pkg.sv
// Shared types, defaults and helpers for the motoro3 ramp sequencer.
package motoro3_ramp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP,
        ST_HOLD,
        ST_DOWN,
        ST_BRAKE
    } state_t;

    localparam int DEF_FREQ_W    = 10;
    localparam int DEF_FREQ_MIN  = 1;
    localparam int DEF_FREQ_MAX  = 1000;
    localparam int DEF_DIV_W     = 16;
    localparam int DEF_BRAKE_CYC = 1000;

    // Saturate a requested frequency into the legal core range.
    function automatic int clamp_freq(input int f, input int lo, input int hi);
        if (f < lo) return lo;
        if (f > hi) return hi;
        return f;
    endfunction

endpackage

// File: rtl/motoro3_ramp_ctrl_if.sv
// Command handshake between a requester and the ramp sequencer.
interface motoro3_ramp_ctrl_if
    import motoro3_ramp_ctrl_pkg::*;
#(
    parameter int FREQ_W = DEF_FREQ_W
);
    logic              cmdValid;
    logic              cmdReady;
    logic              cmdRun;
    logic              cmdDir;
    logic [FREQ_W-1:0] cmdFreq;

    modport master (output cmdValid, output cmdRun, output cmdDir, output cmdFreq, input cmdReady);
    modport slave  (input cmdValid, input cmdRun, input cmdDir, input cmdFreq, output cmdReady);
endinterface

// File: rtl/motoro3_ramp_ctrl_tick_div.sv
// Clock divider producing a one-cycle tick every max(div,1) enabled clocks.
module motoro3_tick_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] lim;

    // A zero divider behaves like one: tick on every enabled cycle.
    always_comb lim = (div == '0) ? '0 : div - DIV_W'(1);

    // >= so that a divider shrunk below the running count fires at once.
    assign tick = en && (cnt >= lim);

    // Count while enabled, restart on tick or on an explicit clear.
    always_ff @(posedge clk) begin
        if (!nRst || clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
endmodule

// File: rtl/motoro3_ramp_ctrl.sv
// Sequencer in front of the motoro3 core: ramps frequency with INC/DEC pulses,
// ramps down and brakes before a direction flip or a stop.
module motoro3_ramp_ctrl
    import motoro3_ramp_ctrl_pkg::*;
#(
    parameter int FREQ_W    = DEF_FREQ_W,
    parameter int FREQ_MIN  = DEF_FREQ_MIN,
    parameter int FREQ_MAX  = DEF_FREQ_MAX,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int BRAKE_CYC = DEF_BRAKE_CYC
) (
    input  logic                clk,
    input  logic                nRst,
    motoro3_ramp_ctrl_if.slave  cmd,
    input  logic [DIV_W-1:0]    rampDiv,
    output logic                m3start,
    output logic                m3forceStop,
    output logic                m3invRotate,
    output logic                m3freqINC,
    output logic                m3freqDEC,
    output logic [FREQ_W-1:0]   curFreq,
    output logic                atTarget
);
    localparam logic [FREQ_W-1:0] F_MIN     = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0] F_MAX     = FREQ_W'(FREQ_MAX);
    localparam logic [DIV_W-1:0]  BRAKE_DIV = DIV_W'(BRAKE_CYC);

    state_t            state, state_nxt;
    logic [FREQ_W-1:0] target, target_nxt, cur_nxt, cmd_target;
    logic              inv_nxt, stop_pend, stop_nxt, rev_pend, rev_nxt;
    logic              inc_nxt, dec_nxt, ready_q;
    logic              accept, entering, ramp_en, brake_en, ramp_tick, brake_tick;

    assign cmd.cmdReady = ready_q;
    assign accept       = cmd.cmdValid && ready_q;
    assign cmd_target   = FREQ_W'(clamp_freq(int'(cmd.cmdFreq), FREQ_MIN, FREQ_MAX));
    assign entering     = (state_nxt != state);
    assign ramp_en      = (state == ST_RAMP) || (state == ST_DOWN);
    assign brake_en     = (state == ST_BRAKE);

    // Step-rate divider; rampDiv is used live so changes apply at the next compare.
    motoro3_tick_div #(.DIV_W(DIV_W)) u_ramp_div (
        .clk(clk), .nRst(nRst), .clr(entering), .en(ramp_en), .div(rampDiv), .tick(ramp_tick)
    );

    // Brake hold timer, same divider with a fixed length.
    motoro3_tick_div #(.DIV_W(DIV_W)) u_brake_div (
        .clk(clk), .nRst(nRst), .clr(entering), .en(brake_en), .div(BRAKE_DIV), .tick(brake_tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!nRst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state, frequency tracking and pending-request decisions.
    always_comb begin
        state_nxt  = state;
        cur_nxt    = curFreq;
        target_nxt = target;
        inv_nxt    = m3invRotate;
        stop_nxt   = stop_pend;
        rev_nxt    = rev_pend;
        inc_nxt    = 1'b0;
        dec_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && cmd.cmdRun) begin
                    state_nxt  = ST_RAMP;
                    inv_nxt    = cmd.cmdDir;
                    cur_nxt    = F_MIN;
                    target_nxt = cmd_target;
                end
            end
            ST_RAMP, ST_HOLD: begin
                if (accept && !cmd.cmdRun) begin
                    stop_nxt  = 1'b1;
                    state_nxt = ST_DOWN;
                end else if (accept && (cmd.cmdDir != m3invRotate)) begin
                    rev_nxt    = 1'b1;
                    target_nxt = cmd_target;
                    state_nxt  = ST_DOWN;
                end else begin
                    // A same-direction run command retargets immediately.
                    if (accept) target_nxt = cmd_target;
                    if (curFreq == target_nxt) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_RAMP;
                        if (ramp_tick) begin
                            if (curFreq < target_nxt && curFreq < F_MAX) begin
                                cur_nxt = curFreq + FREQ_W'(1);
                                inc_nxt = 1'b1;
                            end else if (curFreq > target_nxt && curFreq > F_MIN) begin
                                cur_nxt = curFreq - FREQ_W'(1);
                                dec_nxt = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_DOWN: begin
                if (curFreq == F_MIN) begin
                    state_nxt = ST_BRAKE;
                end else if (ramp_tick && curFreq > F_MIN) begin
                    cur_nxt = curFreq - FREQ_W'(1);
                    dec_nxt = 1'b1;
                end
            end
            ST_BRAKE: begin
                if (brake_tick) begin
                    if (stop_pend) begin
                        state_nxt  = ST_IDLE;
                        cur_nxt    = '0;
                        target_nxt = '0;
                        stop_nxt   = 1'b0;
                        rev_nxt    = 1'b0;
                    end else begin
                        state_nxt = ST_RAMP;
                        inv_nxt   = ~m3invRotate;
                        rev_nxt   = 1'b0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs and datapath, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            curFreq     <= '0;
            target      <= '0;
            m3invRotate <= 1'b0;
            stop_pend   <= 1'b0;
            rev_pend    <= 1'b0;
            m3freqINC   <= 1'b0;
            m3freqDEC   <= 1'b0;
            m3start     <= 1'b0;
            m3forceStop <= 1'b1;
            atTarget    <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            curFreq     <= cur_nxt;
            target      <= target_nxt;
            m3invRotate <= inv_nxt;
            stop_pend   <= stop_nxt;
            rev_pend    <= rev_nxt;
            m3freqINC   <= inc_nxt;
            m3freqDEC   <= dec_nxt;
            m3start     <= (state_nxt != ST_IDLE);
            m3forceStop <= (state_nxt == ST_IDLE) || (state_nxt == ST_BRAKE);
            atTarget    <= (state_nxt == ST_HOLD);
            ready_q     <= (state_nxt == ST_IDLE) || (state_nxt == ST_RAMP) || (state_nxt == ST_HOLD);
        end
    end
endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// Bench for motoro3_ramp_ctrl: command table, corner sequences and a random
// command stream scored against a command-level model of the sequencer.
module tb_motoro3_ramp_ctrl;
    localparam int BRAKE = 1000;

    logic        clk  = 1'b0;
    logic        nRst = 1'b0;
    logic [15:0] rampDiv = 16'd4;
    logic        m3start, m3forceStop, m3invRotate, m3freqINC, m3freqDEC, atTarget;
    logic [9:0]  curFreq;

    motoro3_ramp_ctrl_if #(.FREQ_W(10)) cmd ();

    motoro3_ramp_ctrl dut (
        .clk(clk), .nRst(nRst), .cmd(cmd), .rampDiv(rampDiv),
        .m3start(m3start), .m3forceStop(m3forceStop), .m3invRotate(m3invRotate),
        .m3freqINC(m3freqINC), .m3freqDEC(m3freqDEC), .curFreq(curFreq), .atTarget(atTarget)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       dir;
        logic [9:0] freq;
        logic [15:0] div;
        int         exp_f;
        logic       exp_dir;
        int         exp_inc;
        int         exp_dec;
    } vec_t;

    int tests = 0, fails = 0, cyc = 0;
    int inc_cnt = 0, dec_cnt = 0, last_step = -1, brake_len = 0;
    int first_step_cyc = -1, acc_cyc = 0;
    logic [9:0]  prev_f = '0;
    logic [15:0] prev_div = '0;
    bit          have_prev = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int eff(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    // Per-cycle observations: step pulses move curFreq by one, gap between
    // steps equals the divider, brake lasts BRAKE clocks.
    task automatic monitor();
        if (!nRst) begin
            have_prev = 0;
            last_step = -1;
            brake_len = 0;
        end else begin
            if (rampDiv != prev_div) last_step = -1;
            if (m3freqINC || m3freqDEC) begin
                chk("inc_dec_excl", {31'b0, m3freqINC && m3freqDEC}, 0);
                if (have_prev) begin
                    if (m3freqINC) chk("inc_step", int'(curFreq), int'(prev_f) + 1);
                    else           chk("dec_step", int'(curFreq), int'(prev_f) - 1);
                end
                chk("freq_range", {31'b0, (curFreq >= 10'd1) && (curFreq <= 10'd1000)}, 1);
                if (m3freqINC) inc_cnt++;
                else           dec_cnt++;
                if (first_step_cyc < 0) first_step_cyc = cyc;
                if (last_step >= 0) chk("step_gap", cyc - last_step, eff(rampDiv));
                last_step = cyc;
            end
            if (atTarget || m3forceStop) last_step = -1;
            if (m3start && m3forceStop) begin
                brake_len++;
            end else if (brake_len != 0) begin
                chk("brake_len", brake_len, BRAKE);
                brake_len = 0;
            end
            have_prev = 1;
        end
        prev_f   = curFreq;
        prev_div = rampDiv;
    endtask

    task automatic step_clk();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic issue(input logic run, input logic dir, input logic [9:0] f);
        cmd.cmdValid = 1'b1;
        cmd.cmdRun   = run;
        cmd.cmdDir   = dir;
        cmd.cmdFreq  = f;
        for (int i = 0; i < 5000; i++) begin
            if (cmd.cmdReady === 1'b1) begin
                step_clk();
                cmd.cmdValid   = 1'b0;
                acc_cyc        = cyc;
                first_step_cyc = -1;
                return;
            end
            step_clk();
        end
        cmd.cmdValid = 1'b0;
        chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_settle(input bit run, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (run ? (atTarget === 1'b1) : (m3start === 1'b0)) return;
            step_clk();
        end
        chk(run ? "hold_timeout" : "idle_timeout", 0, 1);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int i0, d0;
        rampDiv = v.div;
        step_clk();
        i0 = inc_cnt;
        d0 = dec_cnt;
        issue(v.run, v.dir, v.freq);
        wait_settle(v.exp_f != 0, 3000 + (v.exp_inc + v.exp_dec + 2) * eff(v.div));
        repeat (3) step_clk();
        chk($sformatf("%s_freq", nm), int'(curFreq), v.exp_f);
        chk($sformatf("%s_dir", nm), {31'b0, m3invRotate}, {31'b0, v.exp_dir});
        chk($sformatf("%s_start", nm), {31'b0, m3start}, {31'b0, v.exp_f != 0});
        chk($sformatf("%s_fstop", nm), {31'b0, m3forceStop}, {31'b0, v.exp_f == 0});
        chk($sformatf("%s_attgt", nm), {31'b0, atTarget}, {31'b0, v.exp_f != 0});
        chk($sformatf("%s_incs", nm), inc_cnt - i0, v.exp_inc);
        chk($sformatf("%s_decs", nm), dec_cnt - d0, v.exp_dec);
        if (v.exp_inc + v.exp_dec > 0)
            chk($sformatf("%s_lat", nm), first_step_cyc - acc_cyc, eff(v.div));
    endtask

    vec_t tbl[12];

    initial begin
        int i0, d0, t, f_m;
        bit run_m, dir_m, run, dir;
        vec_t v;

        cmd.cmdValid = 1'b0;
        cmd.cmdRun   = 1'b0;
        cmd.cmdDir   = 1'b0;
        cmd.cmdFreq  = '0;

        //          run   dir   freq      div     f     dir  inc  dec
        tbl[0]  = '{1'b1, 1'b0, 10'd5,    16'd4, 5,    1'b0, 4,   0};
        tbl[1]  = '{1'b1, 1'b1, 10'd5,    16'd4, 5,    1'b1, 4,   4};
        tbl[2]  = '{1'b0, 1'b1, 10'd0,    16'd3, 0,    1'b1, 0,   4};
        tbl[3]  = '{1'b1, 1'b0, 10'd0,    16'd2, 1,    1'b0, 0,   0};
        tbl[4]  = '{1'b1, 1'b0, 10'd1023, 16'd1, 1000, 1'b0, 999, 0};
        tbl[5]  = '{1'b1, 1'b0, 10'd1022, 16'd1, 1000, 1'b0, 0,   0};
        tbl[6]  = '{1'b0, 1'b0, 10'd0,    16'd0, 0,    1'b0, 0,   999};
        tbl[7]  = '{1'b1, 1'b1, 10'd3,    16'd3, 3,    1'b1, 2,   0};
        tbl[8]  = '{1'b1, 1'b1, 10'd7,    16'd1, 7,    1'b1, 4,   0};
        tbl[9]  = '{1'b1, 1'b1, 10'd2,    16'd2, 2,    1'b1, 0,   5};
        tbl[10] = '{1'b0, 1'b0, 10'd0,    16'd2, 0,    1'b1, 0,   1};
        tbl[11] = '{1'b0, 1'b0, 10'd5,    16'd2, 0,    1'b1, 0,   0};

        // Reset state
        repeat (3) step_clk();
        chk("rst_fstop", {31'b0, m3forceStop}, 1);
        chk("rst_start", {31'b0, m3start}, 0);
        chk("rst_freq", int'(curFreq), 0);
        chk("rst_ready", {31'b0, cmd.cmdReady}, 1);
        chk("rst_attgt", {31'b0, atTarget}, 0);
        chk("rst_inv", {31'b0, m3invRotate}, 0);
        chk("rst_pulses", {30'b0, m3freqINC, m3freqDEC}, 0);
        nRst = 1'b1;
        step_clk();

        for (int k = 0; k < 12; k++) run_vec($sformatf("vec%0d", k), tbl[k]);

        // Reset in the middle of a ramp
        rampDiv = 16'd3;
        step_clk();
        issue(1'b1, 1'b0, 10'd20);
        for (int i = 0; i < 200 && curFreq != 10'd7; i++) step_clk();
        chk("mid_reached7", int'(curFreq), 7);
        nRst = 1'b0;
        step_clk();
        chk("mid_rst_freq", int'(curFreq), 0);
        chk("mid_rst_start", {31'b0, m3start}, 0);
        chk("mid_rst_fstop", {31'b0, m3forceStop}, 1);
        chk("mid_rst_inv", {31'b0, m3invRotate}, 0);
        chk("mid_rst_ready", {31'b0, cmd.cmdReady}, 1);
        chk("mid_rst_pulses", {30'b0, m3freqINC, m3freqDEC}, 0);
        step_clk();
        chk("mid_rst_pulses2", {30'b0, m3freqINC, m3freqDEC}, 0);
        nRst = 1'b1;
        step_clk();
        chk("mid_rst_idle", {31'b0, m3start}, 0);

        // Stop from 3; commands presented during ramp-down are dropped
        run_vec("up3", '{1'b1, 1'b0, 10'd3, 16'd2, 3, 1'b0, 2, 0});
        d0 = dec_cnt;
        issue(1'b0, 1'b0, 10'd0);
        cmd.cmdValid = 1'b1;
        cmd.cmdRun   = 1'b1;
        cmd.cmdDir   = 1'b0;
        cmd.cmdFreq  = 10'd9;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            chk("down_ready", {31'b0, cmd.cmdReady}, 0);
        end
        cmd.cmdValid = 1'b0;
        wait_settle(1'b0, 3000);
        chk("stop3_freq", int'(curFreq), 0);
        chk("stop3_decs", dec_cnt - d0, 2);
        repeat (5) step_clk();
        chk("no_queue", {31'b0, m3start}, 0);

        // Divider shrunk below the running count mid-ramp
        rampDiv = 16'd8;
        step_clk();
        i0 = inc_cnt;
        issue(1'b1, 1'b0, 10'd10);
        repeat (5) step_clk();
        rampDiv = 16'd2;
        wait_settle(1'b1, 500);
        chk("live_div_lat", first_step_cyc - acc_cyc, 6);
        chk("live_div_freq", int'(curFreq), 10);
        chk("live_div_incs", inc_cnt - i0, 9);

        // Random command stream against a command-level model
        run_m = 1;
        f_m   = 10;
        dir_m = 0;
        for (int k = 0; k < 40; k++) begin
            run = ($urandom_range(0, 3) != 0);
            dir = 1'($urandom_range(0, 1));
            v.run  = run;
            v.dir  = dir;
            v.freq = 10'($urandom_range(0, 30));
            v.div  = 16'($urandom_range(0, 4));
            t = (v.freq == 10'd0) ? 1 : int'(v.freq);
            v.exp_inc = 0;
            v.exp_dec = 0;
            if (!run) begin
                if (run_m) v.exp_dec = f_m - 1;
                run_m = 0;
                f_m   = 0;
            end else if (!run_m) begin
                v.exp_inc = t - 1;
                run_m = 1;
                dir_m = dir;
                f_m   = t;
            end else if (dir == dir_m) begin
                if (t > f_m) v.exp_inc = t - f_m;
                else         v.exp_dec = f_m - t;
                f_m = t;
            end else begin
                v.exp_dec = f_m - 1;
                v.exp_inc = t - 1;
                dir_m = dir;
                f_m   = t;
            end
            v.exp_f   = f_m;
            v.exp_dir = dir_m;
            run_vec($sformatf("rnd%0d", k), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
